// File: rtl/fixedpoint_addsub_arbiter_pkg.sv
// Shared width helpers and op codes for the fixed-point add/sub arbiter slice.
package fixedpoint_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int aligned_int_len(input int wi1, input int wi2);
        return max_len(wi1, wi2);
    endfunction

    function automatic int aligned_frc_len(input int wf1, input int wf2);
        return max_len(wf1, wf2);
    endfunction

endpackage

// File: rtl/fixedpoint_addsub_arbiter_core.sv
// Combinational fixed-point add/sub: operand alignment, exact sum/difference,
// output formatting and overflow detection.
module fixedpoint_addsub_core
    import fixedpoint_pkg::*;
#(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = max_len(WI1, WI2) + 1,
    parameter int WFO = max_len(WF1, WF2)
) (
    input  logic                   op_i,
    input  logic [WI1+WF1-1:0]     in1_i,
    input  logic [WI2+WF2-1:0]     in2_i,
    output logic [WIO+WFO-1:0]     data_o,
    output logic                   ovf_o
);

    localparam int W1  = WI1 + WF1;
    localparam int W2  = WI2 + WF2;
    localparam int IL  = aligned_int_len(WI1, WI2);
    localparam int FL  = aligned_frc_len(WF1, WF2);
    localparam int SIL = IL + 1;
    localparam int SW  = SIL + FL;
    localparam int RW  = SIL + WFO;
    localparam int OW  = WIO + WFO;

    logic [SW-1:0] a_s;
    logic [SW-1:0] b_s;
    logic [SW-1:0] sum_s;
    logic [RW-1:0] fmt_s;

    // Align both operands to SIL.FL; the extra integer bit keeps -min(in2) exact.
    always_comb begin
        a_s   = {{(SW-W1){in1_i[W1-1]}}, in1_i} << (FL - WF1);
        b_s   = {{(SW-W2){in2_i[W2-1]}}, in2_i} << (FL - WF2);
        sum_s = (op_i == OP_SUB) ? (a_s - b_s) : (a_s + b_s);
    end

    generate
        if (WFO < FL) begin : g_frc_trunc
            assign fmt_s = sum_s[SW-1:FL-WFO];
        end else if (WFO > FL) begin : g_frc_pad
            assign fmt_s = {sum_s, {(WFO-FL){1'b0}}};
        end else begin : g_frc_same
            assign fmt_s = sum_s;
        end

        if (WIO > SIL) begin : g_int_ext
            assign data_o = {{(WIO-SIL){fmt_s[RW-1]}}, fmt_s};
            assign ovf_o  = 1'b0;
        end else if (WIO == SIL) begin : g_int_same
            assign data_o = fmt_s;
            assign ovf_o  = 1'b0;
        end else begin : g_int_wrap
            // Dropped MSBs must all match the kept sign bit for the value to fit.
            assign data_o = fmt_s[OW-1:0];
            assign ovf_o  = !((&fmt_s[RW-1:OW-1]) || (~|fmt_s[RW-1:OW-1]));
        end
    endgenerate

endmodule

// File: rtl/fixedpoint_addsub_arbiter.sv
// Two-requester round-robin front end sharing one fixed-point add/sub core,
// with a registered result slot and a saturating overflow counter.
module fixedpoint_addsub_arbiter
    import fixedpoint_pkg::*;
#(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = max_len(WI1, WI2) + 1,
    parameter int WFO = max_len(WF1, WF2),
    parameter int CW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   r0_valid,
    output logic                   r0_ready,
    input  logic                   r0_op,
    input  logic [WI1+WF1-1:0]     r0_in1,
    input  logic [WI2+WF2-1:0]     r0_in2,
    input  logic                   r1_valid,
    output logic                   r1_ready,
    input  logic                   r1_op,
    input  logic [WI1+WF1-1:0]     r1_in1,
    input  logic [WI2+WF2-1:0]     r1_in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_id,
    output logic [WIO+WFO-1:0]     out_data,
    output logic                   out_ovf,
    input  logic                   ovf_clear,
    output logic [CW-1:0]          ovf_count
);

    localparam int OW = WIO + WFO;

    logic               out_valid_q, out_valid_d;
    logic               out_id_q,    out_id_d;
    logic [OW-1:0]      out_data_q,  out_data_d;
    logic               out_ovf_q,   out_ovf_d;
    logic [CW-1:0]      ovf_count_q, ovf_count_d;
    logic               rr_ptr_q,    rr_ptr_d;

    logic               slot_free_s;
    logic               grant0_s;
    logic               grant1_s;
    logic               accept_s;
    logic               sel_op_s;
    logic [WI1+WF1-1:0] sel_in1_s;
    logic [WI2+WF2-1:0] sel_in2_s;
    logic [OW-1:0]      core_data_s;
    logic               core_ovf_s;

    // Grant logic; nothing is handed out while reset is asserted.
    always_comb begin
        slot_free_s = !out_valid_q || out_ready;
        grant0_s    = !rst && slot_free_s && r0_valid && (!r1_valid || (rr_ptr_q == 1'b0));
        grant1_s    = !rst && slot_free_s && r1_valid && (!r0_valid || (rr_ptr_q == 1'b1));
        accept_s    = grant0_s || grant1_s;
        sel_op_s    = grant1_s ? r1_op  : r0_op;
        sel_in1_s   = grant1_s ? r1_in1 : r0_in1;
        sel_in2_s   = grant1_s ? r1_in2 : r0_in2;
    end

    fixedpoint_addsub_core #(
        .WI1 (WI1),
        .WF1 (WF1),
        .WI2 (WI2),
        .WF2 (WF2),
        .WIO (WIO),
        .WFO (WFO)
    ) u_core (
        .op_i   (sel_op_s),
        .in1_i  (sel_in1_s),
        .in2_i  (sel_in2_s),
        .data_o (core_data_s),
        .ovf_o  (core_ovf_s)
    );

    // Next state of the result slot, round-robin pointer and overflow counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        rr_ptr_d    = rr_ptr_q;
        ovf_count_d = ovf_count_q;

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_id_d    = grant1_s;
            out_data_d  = core_data_s;
            out_ovf_d   = core_ovf_s;
            rr_ptr_d    = !grant1_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (ovf_clear) begin
            ovf_count_d = {CW{1'b0}};
        end else if (out_valid_q && out_ready && out_ovf_q && !(&ovf_count_q)) begin
            ovf_count_d = ovf_count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            ovf_count_d = ovf_count_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_data_q  <= {OW{1'b0}};
            out_ovf_q   <= 1'b0;
            ovf_count_q <= {CW{1'b0}};
            rr_ptr_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            ovf_count_q <= ovf_count_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign r0_ready  = grant0_s;
    assign r1_ready  = grant1_s;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_fixedpoint_addsub_arbiter.sv
// Bench for fixedpoint_addsub_arbiter: a default-width instance (a) and a
// WIO=3 instance (b) share the same inputs and are checked side by side.
module tb_fixedpoint_addsub_arbiter;

    localparam int OWA = 9;
    localparam int OWB = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, r0_valid, r0_op, r1_valid, r1_op, out_ready, ovf_clear;
    logic [6:0] r0_in1, r0_in2, r1_in1, r1_in2;

    logic r0_ready_a, r1_ready_a, out_valid_a, out_id_a, out_ovf_a;
    logic [OWA-1:0] out_data_a;
    logic [7:0] ovf_count_a;
    logic r0_ready_b, r1_ready_b, out_valid_b, out_id_b, out_ovf_b;
    logic [OWB-1:0] out_data_b;
    logic [7:0] ovf_count_b;

    int n_tests = 0;
    int n_fail  = 0;

    fixedpoint_addsub_arbiter u_dut_a (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready_a), .r0_op(r0_op), .r0_in1(r0_in1), .r0_in2(r0_in2),
        .r1_valid(r1_valid), .r1_ready(r1_ready_a), .r1_op(r1_op), .r1_in1(r1_in1), .r1_in2(r1_in2),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_id(out_id_a), .out_data(out_data_a),
        .out_ovf(out_ovf_a), .ovf_clear(ovf_clear), .ovf_count(ovf_count_a)
    );

    fixedpoint_addsub_arbiter #(.WIO(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready_b), .r0_op(r0_op), .r0_in1(r0_in1), .r0_in2(r0_in2),
        .r1_valid(r1_valid), .r1_ready(r1_ready_b), .r1_op(r1_op), .r1_in1(r1_in1), .r1_in2(r1_in2),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_id(out_id_b), .out_data(out_data_b),
        .out_ovf(out_ovf_b), .ovf_clear(ovf_clear), .ovf_count(ovf_count_b)
    );

    // Exact result in units of 2^-4: in1 is x.4, in2 is x.3 (so scaled by 2).
    function automatic int ref_value(input logic op, input logic [6:0] a, input logic [6:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b) * 2;
        return op ? (sa - sb) : (sa + sb);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        r0_valid = 1'b0; r0_op = 1'b0; r0_in1 = 7'd0; r0_in2 = 7'd0;
        r1_valid = 1'b0; r1_op = 1'b0; r1_in1 = 7'd0; r1_in2 = 7'd0;
        out_ready = 1'b0; ovf_clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (out_valid_a !== 1'b0 || out_id_a !== 1'b0 || out_data_a !== 9'd0 || out_ovf_a !== 1'b0 || ovf_count_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b id=%b d=%h o=%b c=%0d, need all zero",
                     out_valid_a, out_id_a, out_data_a, out_ovf_a, ovf_count_a);
        end
        n_tests++;
        if (out_valid_b !== 1'b0 || out_data_b !== 7'd0 || ovf_count_b !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b d=%h c=%0d, need all zero", out_valid_b, out_data_b, ovf_count_b);
        end
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_op = 1'b0; r0_in1 = 7'h18; r0_in2 = 7'h12; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (r0_ready_a !== 1'b1 || r1_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ready: got r0=%b r1=%b, need 1 0", r0_ready_a, r1_ready_a);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid_a !== 1'b1 || out_id_a !== 1'b0 || out_data_a !== 9'h03C || out_ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: got v=%b id=%b d=%h o=%b, need 1 0 03c 0",
                     out_valid_a, out_id_a, out_data_a, out_ovf_a);
        end
    endtask

    task automatic test_sub();
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_op = 1'b1; r1_in1 = 7'h18; r1_in2 = 7'h12; out_ready = 1'b1;
        @(posedge clk); #1;
        r1_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid_a !== 1'b1 || out_id_a !== 1'b1 || out_data_a !== 9'h1F4 || out_ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_result: got v=%b id=%b d=%h o=%b, need 1 1 1f4 0",
                     out_valid_a, out_id_a, out_data_a, out_ovf_a);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_op = 1'b1; r0_in1 = 7'h38; r0_in2 = 7'h40; out_ready = 1'b1;
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid_b !== 1'b1 || out_data_b !== 7'h38 || out_ovf_b !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result_b: got v=%b d=%h o=%b, need 1 38 1", out_valid_b, out_data_b, out_ovf_b);
        end
        n_tests++;
        if (out_data_a !== 9'h0B8 || out_ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_result_a: got d=%h o=%b, need 0b8 0", out_data_a, out_ovf_a);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (ovf_count_b !== 8'd1 || ovf_count_a !== 8'd0 || out_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_count: got b=%0d a=%0d v=%b, need 1 0 0", ovf_count_b, ovf_count_a, out_valid_b);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            r0_valid = 1'b1; r0_op = 1'b0; r0_in1 = 7'h18; r0_in2 = 7'h12;
            r1_valid = 1'b1; r1_op = 1'b1; r1_in1 = 7'h18; r1_in2 = 7'h12;
            out_ready = 1'b1;
            @(negedge clk);
            n_tests++;
            if (r0_ready_a !== ((i % 2) == 0) || r1_ready_a !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: got r0=%b r1=%b, need %0d %0d",
                         i, r0_ready_a, r1_ready_a, (i % 2) == 0, (i % 2) == 1);
            end
            n_tests++;
            if (out_valid_a !== (i > 0)) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got %b, need %0d", i, out_valid_a, i > 0);
            end
            if (i > 0) begin
                n_tests++;
                if (out_id_a !== ((i - 1) % 2) || out_data_a !== (((i - 1) % 2) ? 9'h1F4 : 9'h03C)) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got id=%b d=%h", i, out_id_a, out_data_a);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            r0_in1 = 7'h18; r0_in2 = 7'h12; r0_op = 1'b0;
            r1_in1 = 7'($urandom); r1_in2 = 7'($urandom);
            @(negedge clk);
            n_tests++;
            if (r0_ready_a !== 1'b0 || r1_ready_a !== 1'b0 || out_valid_a !== 1'b1 ||
                out_id_a !== 1'b1 || out_data_a !== 9'h1F4) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got r0=%b r1=%b v=%b id=%b d=%h, need 0 0 1 1 1f4",
                         i, r0_ready_a, r1_ready_a, out_valid_a, out_id_a, out_data_a);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (r0_ready_a !== 1'b1 || r1_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got r0=%b r1=%b, need 1 0", r0_ready_a, r1_ready_a);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid_a !== 1'b1 || out_id_a !== 1'b0 || out_data_a !== 9'h03C) begin
            n_fail++;
            $display("FAIL bp_after: got v=%b id=%b d=%h, need 1 0 03c", out_valid_a, out_id_a, out_data_a);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_op = 1'b0; r0_in1 = 7'h18; r0_in2 = 7'h12; out_ready = 1'b0;
        @(posedge clk); #1;
        r0_valid = 1'b0;
        n_tests++;
        if (out_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got v=%b, need 1", out_valid_a);
        end
        #2;
        rst = 1'b1; r0_valid = 1'b1;
        #1;
        n_tests++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || r0_ready_a !== 1'b0 || r1_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: got v=%b vb=%b r0=%b r1=%b, need 0 0 0 0",
                     out_valid_a, out_valid_b, r0_ready_a, r1_ready_a);
        end
        @(negedge clk);
        rst = 1'b0; r0_valid = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            @(posedge clk); #1;
            r0_valid = 1'b1; r0_op = 1'b1; r0_in1 = 7'h38; r0_in2 = 7'h40; out_ready = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (ovf_count_b !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_reach: got %0d, need 255", ovf_count_b);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (ovf_count_b !== 8'd255 || out_ovf_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got c=%0d o=%b, need 255 1", ovf_count_b, out_ovf_b);
        end
        @(posedge clk); #1;
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0; r0_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ovf_count_b !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_clear: got %0d, need 0", ovf_count_b);
        end
    endtask

    task automatic test_random();
        logic m_valid, m_id, m_rr, m_oa, m_ob, g0, g1, sf;
        logic [OWA-1:0] m_da;
        logic [OWB-1:0] m_db;
        int cnt_a, cnt_b, v;
        apply_reset();
        m_valid = 1'b0; m_id = 1'b0; m_rr = 1'b0; m_oa = 1'b0; m_ob = 1'b0;
        m_da = '0; m_db = '0; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            r0_valid = 1'($urandom_range(0, 1)); r0_op = 1'($urandom_range(0, 1));
            r0_in1 = 7'($urandom); r0_in2 = 7'($urandom);
            r1_valid = 1'($urandom_range(0, 1)); r1_op = 1'($urandom_range(0, 1));
            r1_in1 = 7'($urandom); r1_in2 = 7'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clear = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            sf = !m_valid || out_ready;
            g0 = sf && r0_valid && (!r1_valid || !m_rr);
            g1 = sf && r1_valid && (!r0_valid || m_rr);
            n_tests++;
            if (r0_ready_a !== g0 || r1_ready_a !== g1 || r0_ready_b !== g0 || r1_ready_b !== g1) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d]: got a=%b%b b=%b%b, need %b%b",
                         i, r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b, g0, g1);
            end
            n_tests++;
            if (out_valid_a !== m_valid || out_valid_b !== m_valid) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: got a=%b b=%b, need %b", i, out_valid_a, out_valid_b, m_valid);
            end
            if (m_valid) begin
                n_tests++;
                if (out_id_a !== m_id || out_data_a !== m_da || out_ovf_a !== m_oa ||
                    out_id_b !== m_id || out_data_b !== m_db || out_ovf_b !== m_ob) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: got a=%b/%h/%b b=%b/%h/%b, need %b/%h/%b %h/%b",
                             i, out_id_a, out_data_a, out_ovf_a, out_id_b, out_data_b, out_ovf_b,
                             m_id, m_da, m_oa, m_db, m_ob);
                end
            end
            n_tests++;
            if (ovf_count_a !== 8'(cnt_a) || ovf_count_b !== 8'(cnt_b)) begin
                n_fail++;
                $display("FAIL rnd_count[%0d]: got a=%0d b=%0d, need %0d %0d", i, ovf_count_a, ovf_count_b, cnt_a, cnt_b);
            end
            if (ovf_clear) begin
                cnt_a = 0; cnt_b = 0;
            end else if (m_valid && out_ready) begin
                if (m_oa && cnt_a < 255) cnt_a++;
                if (m_ob && cnt_b < 255) cnt_b++;
            end
            if (g0 || g1) begin
                v = g1 ? ref_value(r1_op, r1_in1, r1_in2) : ref_value(r0_op, r0_in1, r0_in2);
                m_da = OWA'(v); m_oa = (v < -256) || (v > 255);
                m_db = OWB'(v); m_ob = (v < -64) || (v > 63);
                m_id = g1; m_rr = g0; m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
